// File: rtl/div_unit_pkg.sv
// Shared definitions for the divide unit: ALU opcode encodings and FSM states.
// Any ALU or decoder that issues divide opcodes imports this package.
`timescale 1ns/1ps
package div_unit_pkg;

    localparam logic [4:0] ALU_DIV  = 5'd12;
    localparam logic [4:0] ALU_DIVU = 5'd13;
    localparam logic [4:0] ALU_REM  = 5'd14;
    localparam logic [4:0] ALU_REMU = 5'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FINAL = 2'd2
    } div_state_e;

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

    function automatic logic is_signed_op(input logic [4:0] op);
        return (op == ALU_DIV) || (op == ALU_REM);
    endfunction

    function automatic logic is_rem_op(input logic [4:0] op);
        return (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative RV32M divider: restoring radix-2, one quotient bit per cycle,
// with single-cycle handling of divide-by-zero and signed overflow.
`timescale 1ns/1ps
module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [4:0]      ALUOp,
    input  logic [XLEN-1:0] alu_in1,
    input  logic [XLEN-1:0] alu_in2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state;
    logic [5:0]      cnt;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quot;
    logic [XLEN-1:0] dvs;
    logic            is_rem;
    logic            neg_q;
    logic            neg_r;
    logic            special;

    logic            accept;
    logic            sgn;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            overflow;
    logic [XLEN-1:0] special_res;

    logic [XLEN:0]   rem_sh;
    logic            fits;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quot_next;
    logic [XLEN-1:0] final_res;

    // Accept qualification; flush priority is handled in the sequential block.
    always_comb begin
        accept   = start && !busy && is_div_op(ALUOp);
        sgn      = is_signed_op(ALUOp);
        a_neg    = sgn && alu_in1[XLEN-1];
        b_neg    = sgn && alu_in2[XLEN-1];
        a_mag    = a_neg ? (~alu_in1 + 1'b1) : alu_in1;
        b_mag    = b_neg ? (~alu_in2 + 1'b1) : alu_in2;
        div_zero = (alu_in2 == '0);
        overflow = sgn && (alu_in1 == MIN_NEG) && (alu_in2 == '1);
        if (div_zero) begin
            special_res = is_rem_op(ALUOp) ? alu_in1 : '1;
        end else begin
            special_res = is_rem_op(ALUOp) ? '0 : MIN_NEG;
        end
    end

    // One restoring step; the difference is only used when it does not borrow,
    // so the low XLEN bits of the subtraction are exact.
    always_comb begin
        rem_sh    = {rem, quot[XLEN-1]};
        fits      = (rem_sh >= {1'b0, dvs});
        rem_next  = fits ? (rem_sh[XLEN-1:0] - dvs) : rem_sh[XLEN-1:0];
        quot_next = {quot[XLEN-2:0], fits};
        if (is_rem) begin
            final_res = neg_r ? (~rem + 1'b1) : rem;
        end else begin
            final_res = neg_q ? (~quot + 1'b1) : quot;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            rem     <= '0;
            quot    <= '0;
            dvs     <= '0;
            is_rem  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            special <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // busy stays high through the done cycle, which also blocks
                    // a back-to-back accept there.
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (accept) begin
                        busy    <= 1'b1;
                        is_rem  <= is_rem_op(ALUOp);
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                        dvs     <= b_mag;
                        cnt     <= '0;
                        if (div_zero || overflow) begin
                            special <= 1'b1;
                            result  <= special_res;
                            done    <= 1'b1;
                            state   <= ST_FINAL;
                        end else begin
                            special <= 1'b0;
                            rem     <= '0;
                            quot    <= a_mag;
                            state   <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    rem  <= rem_next;
                    quot <= quot_next;
                    cnt  <= cnt + 6'd1;
                    if (cnt == 6'(XLEN - 1)) begin
                        state <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    // Special cases already pulsed done on entry to this state.
                    state <= ST_IDLE;
                    if (special) begin
                        done <= 1'b0;
                        busy <= 1'b0;
                    end else begin
                        result <= final_res;
                        done   <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed quotients/remainders, latency,
// special cases, ignored strobes, flush and asynchronous reset.
`timescale 1ns/1ps
module tb_div_unit;
    import div_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  ALUOp;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    div_unit #(.XLEN(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .ALUOp   (ALUOp),
        .alu_in1 (alu_in1),
        .alu_in2 (alu_in2),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle, sampling 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a strobe, cross the accept edge, then scramble the inputs so the
    // operation must rely on its latched copies. Returns in cycle 1.
    task automatic start_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start   = 1'b1;
        ALUOp   = op;
        alu_in1 = a;
        alu_in2 = b;
        step();
        start   = 1'b0;
        ALUOp   = 5'(ALU_DIVU);
        alu_in1 = $urandom;
        alu_in2 = $urandom;
    endtask

    task automatic run_normal(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp, input string tag);
        int bad;
        bad = 0;
        start_op(op, a, b);
        for (int c = 1; c <= 33; c++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            step();
        end
        chk({tag, "_busy_window"}, bad, 0);
        chk({tag, "_done_c34"}, done, 1);
        chk({tag, "_busy_c34"}, busy, 1);
        chk({tag, "_result"}, result, exp);
        step();
        chk({tag, "_done_fall"}, done, 0);
        chk({tag, "_busy_fall"}, busy, 0);
    endtask

    task automatic run_special(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp, input string tag);
        start_op(op, a, b);
        chk({tag, "_done_c1"}, done, 1);
        chk({tag, "_busy_c1"}, busy, 1);
        chk({tag, "_result"}, result, exp);
        step();
        chk({tag, "_done_fall"}, done, 0);
        chk({tag, "_busy_fall"}, busy, 0);
        chk({tag, "_result_hold"}, result, exp);
    endtask

    initial begin
        int dn;
        rst     = 1'b1;
        start   = 1'b0;
        flush   = 1'b0;
        ALUOp   = '0;
        alu_in1 = '0;
        alu_in2 = '0;
        repeat (2) step();
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_result", result, 0);
        @(negedge clk);
        rst = 1'b0;

        // Non-divide opcode and a flush-coincident start are both ignored.
        start_op(5'd0, 32'd20, 32'd6);
        chk("nondiv_ignored", busy, 0);
        @(negedge clk);
        start = 1'b1; ALUOp = ALU_DIV; alu_in1 = 32'd20; alu_in2 = 32'd6; flush = 1'b1;
        step();
        start = 1'b0; flush = 1'b0;
        chk("flush_start_ignored", busy, 0);
        step();
        chk("flush_start_no_done", done, 0);

        run_normal(ALU_DIV,  32'd20,        32'd6,         32'd3,         "div_20_6");
        run_normal(ALU_REM,  32'd20,        32'd6,         32'd2,         "rem_20_6");
        run_normal(ALU_DIV,  32'hFFFF_FFEC, 32'hFFFF_FFFB, 32'd4,         "div_m20_m5");
        run_normal(ALU_REM,  32'hFFFF_FFEC, 32'd6,         32'hFFFF_FFFE, "rem_m20_6");
        run_normal(ALU_DIVU, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, "divu_max_2");

        run_special(ALU_DIVU, 32'd100,       32'd0,         32'hFFFF_FFFF, "divu_by0");
        run_special(ALU_REM,  32'd123,       32'd0,         32'd123,       "rem_by0");
        run_special(ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        run_special(ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "rem_ovf");

        // Strobe during CALC iteration 10 must not disturb the running op.
        start_op(ALU_DIVU, 32'hFFFF_FFFF, 32'd2);
        repeat (9) step();
        start = 1'b1; ALUOp = ALU_REM; alu_in1 = 32'd5; alu_in2 = 32'd3;
        step();
        start = 1'b0;
        repeat (23) step();
        chk("midstart_done_c34", done, 1);
        chk("midstart_result", result, 32'h7FFF_FFFF);
        dn = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (done === 1'b1) dn++;
        end
        chk("midstart_no_extra_done", dn, 0);
        chk("midstart_idle", busy, 0);

        // Flush at iteration 15: back to idle, no done, result retained.
        start_op(ALU_DIV, 32'd20, 32'd6);
        repeat (14) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_done", done, 0);
        chk("flush_result_kept", result, 32'h7FFF_FFFF);
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) dn++;
            step();
        end
        chk("flush_no_done", dn, 0);
        chk("flush_result_still", result, 32'h7FFF_FFFF);
        run_normal(ALU_DIVU, 32'd100, 32'd7, 32'd14, "divu_100_7");

        // Asynchronous reset between edges in the middle of CALC.
        start_op(ALU_DIV, 32'd20, 32'd6);
        repeat (9) step();
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_result", result, 0);
        @(negedge clk);
        rst = 1'b0;
        run_normal(ALU_REMU, 32'd100, 32'd7, 32'd2, "remu_100_7");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
